// File: rtl/game_tick_scheduler_if.sv
`timescale 1ns/1ps
// Move handshake between the tick scheduler (master) and game_logic (slave):
// request/done plus the direction and game events that travel with it.
interface game_tick_scheduler_if;
  logic       update_req;
  logic [1:0] dir_latched;
  logic       update_done;
  logic       food_eaten;
  logic       game_over;

  modport master (
    output update_req,
    output dir_latched,
    input  update_done,
    input  food_eaten,
    input  game_over
  );

  modport slave (
    input  update_req,
    input  dir_latched,
    output update_done,
    output food_eaten,
    output game_over
  );
endinterface

// File: rtl/game_tick_scheduler.sv
`timescale 1ns/1ps
// Snake move scheduler: turns vertical-blank edges into a paced req/done
// handshake towards game_logic, shortening the move period as food is eaten.
module game_tick_scheduler #(
  parameter int V_ACTIVE    = 480,
  parameter int FRAMES_INIT = 30,
  parameter int FRAMES_MIN  = 6,
  parameter int SPEED_STEP  = 2,
  parameter int SPEED_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            y_in,
  input  logic [1:0]            direction,
  input  logic                  pause,
  game_tick_scheduler_if.master gl,
  output logic                  frame_pulse,
  output logic [3:0]            speed_level,
  output logic                  overrun,
  output logic                  halted
);

  localparam int              FL_W        = $clog2(FRAMES_INIT + 1);
  localparam logic [9:0]      V_ACTIVE_L  = 10'(V_ACTIVE);
  localparam logic [3:0]      SPEED_MAX_L = 4'(SPEED_MAX);
  localparam logic [FL_W-1:0] FL_ONE      = FL_W'(1);
  localparam logic [FL_W-1:0] FL_INIT     = FL_W'(FRAMES_INIT);

  typedef enum logic [1:0] {ST_RUN, ST_ISSUE, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic            update_req_q, update_req_d;
  logic [1:0]      dir_latched_q, dir_latched_d;
  logic [1:0]      dir_pending_q, dir_pending_d;
  logic            frame_pulse_q, frame_pulse_d;
  logic [3:0]      speed_level_q, speed_level_d;
  logic            overrun_q, overrun_d;
  logic            halted_q, halted_d;
  logic [FL_W-1:0] frames_left_q, frames_left_d;
  logic            y_prev_blank_q, y_prev_blank_d;

  logic            blank;
  int              period_raw;
  logic [FL_W-1:0] period;

  // Signed arithmetic so a large speed_level cannot wrap to a long period.
  always_comb begin
    period_raw = FRAMES_INIT - SPEED_STEP * int'(speed_level_q);
    period     = (period_raw < FRAMES_MIN) ? FL_W'(FRAMES_MIN) : FL_W'(period_raw);
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d        = state_q;
    update_req_d   = 1'b0;
    dir_latched_d  = dir_latched_q;
    frames_left_d  = frames_left_q;
    overrun_d      = overrun_q;
    halted_d       = halted_q;

    blank          = (y_in >= V_ACTIVE_L);
    frame_pulse_d  = blank && !y_prev_blank_q;
    y_prev_blank_d = blank;

    speed_level_d  = speed_level_q;
    if (gl.food_eaten && speed_level_q != SPEED_MAX_L) begin
      speed_level_d = speed_level_q + 4'd1;
    end

    // A request to reverse onto the snake's own body is simply dropped.
    dir_pending_d = (direction == (dir_latched_q ^ 2'b10)) ? dir_pending_q : direction;

    if (gl.game_over) begin
      state_d  = ST_HALT;
      halted_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (frame_pulse_q && !pause) begin
            if (frames_left_q == FL_ONE) begin
              frames_left_d = period;
              dir_latched_d = dir_pending_q;
              state_d       = ST_ISSUE;
            end else begin
              frames_left_d = frames_left_q - FL_ONE;
            end
          end
        end
        ST_ISSUE: begin
          if (gl.update_done) begin
            state_d = ST_RUN;
          end else begin
            update_req_d = 1'b1;
            // Counting parks at 1 so the missed tick fires on return to RUN.
            if (frame_pulse_q) begin
              overrun_d = 1'b1;
              if (!pause && frames_left_q != FL_ONE) begin
                frames_left_d = frames_left_q - FL_ONE;
              end
            end
          end
        end
        ST_HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch only.
    if (!reset) begin
      state_q        <= ST_RUN;
      update_req_q   <= 1'b0;
      dir_latched_q  <= 2'b01;
      dir_pending_q  <= 2'b01;
      frame_pulse_q  <= 1'b0;
      speed_level_q  <= 4'd0;
      overrun_q      <= 1'b0;
      halted_q       <= 1'b0;
      frames_left_q  <= FL_INIT;
      y_prev_blank_q <= 1'b1;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q        <= state_d;
      update_req_q   <= update_req_d;
      dir_latched_q  <= dir_latched_d;
      dir_pending_q  <= dir_pending_d;
      frame_pulse_q  <= frame_pulse_d;
      speed_level_q  <= speed_level_d;
      overrun_q      <= overrun_d;
      halted_q       <= halted_d;
      frames_left_q  <= frames_left_d;
      y_prev_blank_q <= y_prev_blank_d;
    end
  end

  assign gl.update_req  = update_req_q;
  assign gl.dir_latched = dir_latched_q;
  assign frame_pulse    = frame_pulse_q;
  assign speed_level    = speed_level_q;
  assign overrun        = overrun_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for game_tick_scheduler: a frame-level model predicts
// frame pulses and move requests; a negedge monitor pops and compares them.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] y_in;
  logic [1:0] direction;
  logic       pause;
  logic       frame_pulse;
  logic [3:0] speed_level;
  logic       overrun;
  logic       halted;

  game_tick_scheduler_if gl_if ();

  game_tick_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .y_in        (y_in),
    .direction   (direction),
    .pause       (pause),
    .gl          (gl_if),
    .frame_pulse (frame_pulse),
    .speed_level (speed_level),
    .overrun     (overrun),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (one step per frame) ----------------
  typedef struct {
    int         cyc;
    logic [1:0] dir;
  } req_t;

  int   pulse_q[$];
  req_t req_q[$];

  int         m_left;
  int         m_speed;
  logic [1:0] m_dir;
  logic [1:0] m_pending;
  bit         m_issue;
  bit         m_overrun;
  bit         m_halted;

  logic [1:0] g_dir;
  bit         g_pause;

  function automatic int period_of(input int s);
    int p;
    p = 30 - 2 * s;
    return (p < 6) ? 6 : p;
  endfunction

  task automatic model_reset();
    m_left    = 30;
    m_speed   = 0;
    m_dir     = 2'b01;
    m_pending = 2'b01;
    m_issue   = 0;
    m_overrun = 0;
    m_halted  = 0;
  endtask

  task automatic follow_direction();
    if (g_dir != (m_dir ^ 2'b10)) m_pending = g_dir;
  endtask

  // e = the clock edge that first samples the blank line.
  task automatic model_tick(input int e);
    pulse_q.push_back(e);
    if (m_halted) return;
    if (!m_issue) begin
      if (!g_pause) begin
        if (m_left == 1) begin
          m_left  = period_of(m_speed);
          m_dir   = m_pending;
          m_issue = 1;
          req_q.push_back('{cyc: e + 2, dir: m_dir});
          follow_direction();
        end else begin
          m_left--;
        end
      end
    end else begin
      m_overrun = 1;
      if (!g_pause && m_left > 1) m_left--;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    req_t       r;
    logic       prev_req;
    logic [1:0] cur_dir;
    prev_req = 1'b0;
    cur_dir  = 2'b01;
    forever begin
      @(negedge clk);
      if (frame_pulse === 1'b1) begin
        check("pulse_expected", 32'(pulse_q.size() > 0), 1);
        if (pulse_q.size() > 0) check("pulse_cycle", cyc, pulse_q.pop_front());
      end
      if (gl_if.update_req === 1'b1 && prev_req !== 1'b1) begin
        check("req_expected", 32'(req_q.size() > 0), 1);
        if (req_q.size() > 0) begin
          r = req_q.pop_front();
          check("req_cycle", cyc, r.cyc);
          check("req_dir", gl_if.dir_latched, r.dir);
          cur_dir = r.dir;
        end
      end else if (gl_if.update_req === 1'b1) begin
        check("dir_hold", gl_if.dir_latched, cur_dir);
      end
      prev_req = gl_if.update_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(input bit do_done, input bit do_food);
    int lo_n;
    int hi_n;
    lo_n = $urandom_range(2, 6);
    hi_n = $urandom_range(3, 6);
    if (m_issue && !do_done) check("req_held", gl_if.update_req, 1);
    y_in                = 10'($urandom_range(0, 479));
    direction           = g_dir;
    pause               = g_pause;
    gl_if.update_done   = do_done;
    gl_if.food_eaten    = do_food;
    @(posedge clk); #1;
    gl_if.update_done = 1'b0;
    gl_if.food_eaten  = 1'b0;
    if (do_done) begin
      check("req_drop", gl_if.update_req, 0);
      m_issue = 0;
    end
    if (do_food && m_speed < 15) m_speed++;
    follow_direction();
    repeat (lo_n) begin
      @(posedge clk); #1;
      y_in = 10'($urandom_range(0, 479));
    end
    y_in = 10'($urandom_range(480, 524));
    model_tick(cyc + 1);
    repeat (hi_n) begin
      @(posedge clk); #1;
      y_in = 10'($urandom_range(480, 524));
    end
    check("overrun", overrun, m_overrun);
    check("speed_level", speed_level, m_speed);
    check("halted", halted, m_halted);
  endtask

  task automatic check_reset_outputs();
    check("rst_update_req", gl_if.update_req, 0);
    check("rst_dir_latched", gl_if.dir_latched, 2'b01);
    check("rst_frame_pulse", frame_pulse, 0);
    check("rst_speed_level", speed_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_halted", halted, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    model_reset();
    reset = 1'b1;
  endtask

  task automatic run_until_issue(input int max_frames);
    for (int i = 0; i < max_frames && !m_issue; i++) frame(0, 0);
    check("req_up", gl_if.update_req, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b0;
    y_in              = 10'd500;
    direction         = 2'b01;
    pause             = 1'b0;
    gl_if.update_done = 1'b0;
    gl_if.food_eaten  = 1'b0;
    gl_if.game_over   = 1'b0;
    g_dir             = 2'b11;
    g_pause           = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;
    @(posedge clk); #1;
    check("no_pulse_after_reset", frame_pulse, 0);

    // Reversal held from reset: the first tick, on frame 30, keeps 01.
    for (int i = 0; i < 30; i++) frame(0, 0);
    check("first_req", gl_if.update_req, 1);

    // Two frames with no done: overrun, still a single request.
    frame(0, 0);
    frame(0, 0);
    g_dir = 2'b00;
    frame(1, 0);
    run_until_issue(40);
    frame(1, 0);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) g_dir = 2'($urandom_range(0, 3));
      g_pause = ($urandom_range(0, 9) == 0);
      if (m_issue) frame($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0);
      else         frame($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end

    // Saturate speed, then stall the handshake past a reload point.
    g_pause = 0;
    for (int i = 0; i < 20; i++) frame(m_issue, 1);
    run_until_issue(40);
    for (int i = 0; i < 8; i++) frame(0, 0);
    frame(1, 0);
    frame(1, 0);

    // Reset mid-handshake.
    run_until_issue(40);
    pulse_reset();

    // Game over while a request is outstanding.
    run_until_issue(40);
    gl_if.game_over = 1'b1;
    @(posedge clk); #1;
    m_halted = 1;
    m_issue  = 0;
    check("go_update_req", gl_if.update_req, 0);
    check("go_halted", halted, 1);
    for (int i = 0; i < 3; i++) frame(1, 0);
    gl_if.game_over = 1'b0;
    frame(1, 0);
    frame(0, 0);
    pulse_reset();

    repeat (4) @(posedge clk);
    #1;
    check("pulse_q_empty", pulse_q.size(), 0);
    check("req_q_empty", req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Sequences the snake game datapath: decides when the game logic may advance one move and which direction it uses.
- Derives a frame strobe from the VGA line counter and counts frames down to a move period that shortens as food is eaten.
- Issues a req/done handshake to game logic, timed to start at vertical blanking so board updates never tear the active picture.
- Sits between joystick_input / VGA_Ctrl (inputs) and game_logic (outputs), on vga_clk.

Parameters:
- V_ACTIVE, 480, first blanking line; y_in >= V_ACTIVE means vertical blank.
- FRAMES_INIT, 30, move period in frames at speed_level 0.
- FRAMES_MIN, 6, floor on the move period.
- SPEED_STEP, 2, frames removed from the period per speed level.
- SPEED_MAX, 15, saturation value of speed_level.

Ports:
- clk  in  1  vga_clk, all logic on the rising edge.
- reset  in  1  synchronous, active-low; 0 while sampled on clk resets every register.
- y_in  in  10  current VGA line (mVGA_Y).
- direction  in  2  joystick direction: 00 up, 01 right, 10 down, 11 left.
- pause  in  1  level; freezes frame counting.
- update_done  in  1  game_logic finished the move; single-cycle pulse or level.
- food_eaten  in  1  one-cycle pulse from game_logic.
- game_over  in  1  level from game_logic.
- update_req  out  1  request one move; held until update_done.
- dir_latched  out  2  direction for the current/next move; stable while update_req=1.
- frame_pulse  out  1  one-cycle strobe at the start of vertical blank.
- speed_level  out  4  current speed level.
- overrun  out  1  sticky; an update was still pending when the next frame started.
- halted  out  1  high in HALT.

Behaviour:
- Reset (reset=0 at a clock edge): state=RUN, update_req=0, dir_latched=01, dir_pending=01, frame_pulse=0, speed_level=0, overrun=0, halted=0, frames_left=FRAMES_INIT, y_prev_blank=1.
  - The y_prev_blank=1 reset value means no frame_pulse fires on the first cycle after reset.
- Blank detect: blank = (y_in >= V_ACTIVE). frame_pulse is registered and goes high the cycle after blank goes 0 to 1. Exactly one pulse per frame.
- Period: period = FRAMES_INIT - SPEED_STEP*speed_level. If that is < FRAMES_MIN or negative, use FRAMES_MIN. Compute at 6-bit signed width or wider.
- Direction filter:
  - Every cycle, dir_pending <= direction unless direction == dir_latched ^ 2'b10 (reversal); a reversal is ignored.
  - dir_latched changes only on the RUN to ISSUE transition.
- FSM states: RUN, ISSUE, HALT.
  - RUN: on frame_pulse with pause=0:
    - if frames_left == 1: reload frames_left=period, dir_latched<=dir_pending, go to ISSUE;
    - else frames_left decrements by 1.
  - RUN with pause=1: frames_left holds.
  - ISSUE: update_req=1. update_req rises the cycle after the ISSUE entry edge, i.e. 2 cycles after frame_pulse is high. Frame counting continues in ISSUE.
  - ISSUE to RUN: on update_done=1, return to RUN; update_req is 0 from the next cycle.
  - Overrun: a frame_pulse seen in ISSUE sets overrun (sticky until reset) and still decrements frames_left; it cannot trigger a second request.
  - If frames_left reaches the reload point while in ISSUE, the tick is deferred: frames_left stays at 1 and the request fires on the first frame_pulse after returning to RUN.
  - update_done in RUN is ignored.
  - pause asserted in ISSUE does not withdraw update_req.
- food_eaten: speed_level += 1, saturating at SPEED_MAX. The new period applies at the next reload, not to the frame count in progress.
- game_over=1 in any state: next state HALT, update_req=0, halted=1. HALT is left only by reset. frame_pulse keeps running in HALT.
- Priority within one cycle: reset > game_over > update_done > frame_pulse.
- Reset asserted mid-handshake drops update_req on the next edge. game_logic must accept an abandoned request.

Test Plan:
- Reset, drive 30 blank rising edges (y 479 to 480), pause=0 → update_req rises 2 cycles after the 30th frame_pulse, dir_latched=01; no request on frames 1–29.
- In ISSUE, hold update_done=0 for 2 frames → overrun=1 after the first pulse, only one request; pulse update_done → update_req=0 next cycle, overrun stays 1.
- direction=11 while dir_latched=01 → at the tick dir_latched stays 01; then direction=00 → the next tick latches 00.
- Pulse food_eaten 20 times → speed_level=15; the period after the next reload is FRAMES_MIN=6 frames; at speed 3 the period is 24.
- pause=1 for 10 frames mid-count → the tick is delayed by exactly 10 frames; game_over=1 during ISSUE → update_req=0 and halted=1 next cycle, and only reset clears them.
- Drop reset for one cycle while update_req=1 → all outputs return to their reset values on that edge.
